// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory boot loader: RAM geometry
// and the loader state encoding.
package mips_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_WORDS  = 64;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_DATA = 3'd1,
    ST_CSUM = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/byte_to_word.sv
// Big-endian byte-to-word assembler: the first byte of each group of four
// becomes the most significant byte of the word.
module byte_to_word (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The fourth byte is combined directly so the caller can register the
  // complete word on the same edge that accepts it.
  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: receives a counted, XOR-checksummed byte image, writes it
// into instruction RAM from word 0 and holds the core in reset until verified.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int MAX_WORDS = IMEM_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = ADDR_W + 1;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  words_q, words_d;
  logic [7:0]        acc_q, acc_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              hold_q, hold_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic        data_byte;
  logic        hdr_ok;
  logic        csum_ok;
  logic        last_word;
  logic        word_valid;
  logic [31:0] word;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on state; a coincident load_req discards the byte.
  assign accept    = in_valid && in_ready && !load_req;
  assign data_byte = accept && (state_q == ST_DATA);
  assign hdr_ok    = (in_data != 8'd0) && (int'(in_data) <= MAX_WORDS);
  assign csum_ok   = (in_data == acc_q);
  assign last_word = ((words_q + CNT_W'(1)) == n_q);

  byte_to_word u_b2w (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (load_req),
    .byte_valid_i (data_byte),
    .byte_i       (in_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load_req) begin
      state_d = ST_HDR;
    end else begin
      case (state_q)
        ST_HDR: begin
          if (accept) state_d = hdr_ok ? ST_DATA : ST_ERR;
        end
        ST_DATA: begin
          if (word_valid && last_word) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (accept) state_d = csum_ok ? ST_RUN : ST_ERR;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    err       = (state_q == ST_ERR);
    state_dbg = state_q;
  end

  // The core is released one cycle after RUN is entered, so done leads the
  // release of cpu_hold by one cycle.
  always_comb begin
    n_d     = n_q;
    acc_d   = acc_q;
    words_d = words_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    hold_d  = (state_q != ST_RUN);
    if (load_req) begin
      hold_d  = 1'b1;
      words_d = '0;
      acc_d   = '0;
      n_d     = '0;
    end else begin
      if (accept && (state_q == ST_HDR) && hdr_ok) begin
        n_d   = in_data[CNT_W-1:0];
        acc_d = in_data;
      end
      if (data_byte) begin
        acc_d = acc_q ^ in_data;
      end
      if (word_valid) begin
        we_d    = 1'b1;
        waddr_d = words_q[ADDR_W-1:0];
        wdata_d = word;
        words_d = words_q + CNT_W'(1);
      end
      if (accept && (state_q == ST_CSUM) && csum_ok) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q     <= '0;
      acc_q   <= '0;
      words_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      n_q     <= n_d;
      acc_q   <= acc_d;
      words_q <= words_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
    end
  end

  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign done         = done_q;
  assign cpu_hold     = hold_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, bad checksum, illegal count,
// maximum image, abort mid-word and reset mid-load.
module tb_imem_loader;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        load_req = 1'b0;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [6:0]  words_loaded;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  int we_cnt   = 0;
  int done_cnt = 0;
  int acc_cnt  = 0;
  logic [37:0] got_mem [0:255];
  logic [37:0] exp_q[$];
  int rd_idx = 0;

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .load_req     (load_req),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  // Capture RAM writes, done pulses and accepted bytes away from the active edge.
  always @(negedge clk) begin
    if (we) begin
      if (we_cnt < 256) got_mem[we_cnt] <= {waddr, wdata};
      we_cnt <= we_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (in_valid && in_ready && !load_req) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    cycles(1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    cycles(1);
    load_req = 1'b0;
  endtask

  task automatic push_word(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_words(input string tag);
    logic [37:0] e;
    check({tag, "_we_count"}, 64'(we_cnt - rd_idx), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < we_cnt) begin
        check({tag, "_word"}, 64'(got_mem[rd_idx]), 64'(e));
        rd_idx++;
      end
    end
    rd_idx = we_cnt;
  endtask

  initial begin
    int done_base;
    int acc_base;
    logic [7:0] csum;
    logic [7:0] b;

    // Reset
    cycles(2);
    check("rst_state", 64'(state_dbg), 64'(ST_HDR));
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    cycles(1);

    // Nominal two-word load, checksum 0A
    done_base = done_cnt;
    push_word(6'd0, 32'h20020005);
    push_word(6'd1, 32'h2003000C);
    send(8'h02);
    send(8'h20); send(8'h02); send(8'h00); send(8'h05);
    send(8'h20); send(8'h03); send(8'h00); send(8'h0C);
    send(8'h0A);
    check("nom_state_run", 64'(state_dbg), 64'(ST_RUN));
    check("nom_done", 64'(done), 64'd1);
    check("nom_hold_1cyc", 64'(cpu_hold), 64'd1);
    idle();
    cycles(1);
    check("nom_hold_2cyc", 64'(cpu_hold), 64'd0);
    check("nom_done_clear", 64'(done), 64'd0);
    check("nom_in_ready", 64'(in_ready), 64'd0);
    check("nom_words", 64'(words_loaded), 64'd2);
    check_words("nom");
    check("nom_done_count", 64'(done_cnt - done_base), 64'd1);

    // Bad checksum
    pulse_load();
    check("bad_state_hdr", 64'(state_dbg), 64'(ST_HDR));
    check("bad_hold", 64'(cpu_hold), 64'd1);
    check("bad_words_clr", 64'(words_loaded), 64'd0);
    done_base = done_cnt;
    push_word(6'd0, 32'h20020005);
    push_word(6'd1, 32'h2003000C);
    send(8'h02);
    send(8'h20); send(8'h02); send(8'h00); send(8'h05);
    send(8'h20); send(8'h03); send(8'h00); send(8'h0C);
    send(8'h00);
    idle();
    cycles(1);
    check("bad_state_err", 64'(state_dbg), 64'(ST_ERR));
    check("bad_err", 64'(err), 64'd1);
    check("bad_in_ready", 64'(in_ready), 64'd0);
    check("bad_hold_err", 64'(cpu_hold), 64'd1);
    check_words("bad");
    check("bad_no_done", 64'(done_cnt - done_base), 64'd0);
    pulse_load();
    check("bad_reload_hdr", 64'(state_dbg), 64'(ST_HDR));
    check("bad_reload_err", 64'(err), 64'd0);

    // Illegal counts 00 and 41
    send(8'h00);
    idle();
    check("cnt0_err", 64'(err), 64'd1);
    pulse_load();
    send(8'h41);
    idle();
    check("cnt65_err", 64'(err), 64'd1);
    check_words("illegal");
    pulse_load();

    // Maximum image: 64 words, in_valid held continuously
    done_base = done_cnt;
    acc_base  = acc_cnt;
    csum = 8'h40;
    send(8'h40);
    for (int k = 0; k < 256; k++) begin
      b = 8'(k);
      csum = csum ^ b;
      send(b);
    end
    for (int w = 0; w < 64; w++) begin
      push_word(6'(w), {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
    end
    send(csum);
    idle();
    check("max_done", 64'(done), 64'd1);
    check("max_state_run", 64'(state_dbg), 64'(ST_RUN));
    cycles(1);
    check("max_hold", 64'(cpu_hold), 64'd0);
    check("max_words", 64'(words_loaded), 64'd64);
    check("max_no_stall", 64'(acc_cnt - acc_base), 64'd258);
    check_words("max");
    check("max_done_count", 64'(done_cnt - done_base), 64'd1);

    // Abort mid-word: byte 77 coincides with load_req and is dropped
    pulse_load();
    acc_base = acc_cnt;
    push_word(6'd0, 32'h11223344);
    send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66);
    in_data  = 8'h77;
    in_valid = 1'b1;
    pulse_load();
    idle();
    check("abort_state_hdr", 64'(state_dbg), 64'(ST_HDR));
    check("abort_words", 64'(words_loaded), 64'd0);
    check("abort_dropped", 64'(acc_cnt - acc_base), 64'd7);
    check_words("abort_partial");
    done_base = done_cnt;
    push_word(6'd0, 32'hAABBCCDD);
    send(8'h01);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    send(8'h01);
    idle();
    check("abort_reload_done", 64'(done), 64'd1);
    check("abort_reload_words", 64'(words_loaded), 64'd1);
    check_words("abort_reload");

    // Reset during DATA with gapped input
    pulse_load();
    push_word(6'd0, 32'h01020304);
    send(8'h03);
    idle();
    for (int i = 1; i <= 5; i++) begin
      send(8'(i));
      idle();
      cycles($urandom_range(0, 2));
    end
    reset = 1'b1;
    cycles(1);
    check("mid_rst_state", 64'(state_dbg), 64'(ST_HDR));
    check("mid_rst_hold", 64'(cpu_hold), 64'd1);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_we", 64'(we), 64'd0);
    check("mid_rst_waddr", 64'(waddr), 64'd0);
    check("mid_rst_wdata", 64'(wdata), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    check_words("mid_rst_partial");
    push_word(6'd0, 32'h12345678);
    send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h09);
    idle();
    check("mid_rst_reload_done", 64'(done), 64'd1);
    cycles(1);
    check("mid_rst_reload_hold", 64'(cpu_hold), 64'd0);
    check_words("mid_rst_reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Serial boot loader that writes a program image into the processor's instruction RAM, the write-side counterpart of the read-only instruction memory port.
- Consumes a byte stream with a valid/ready handshake, normally from the board UART receiver.
- Assembles big-endian 32-bit instruction words and writes them to consecutive word addresses from 0.
- Holds the single-cycle MIPS core in reset until a complete, checksum-verified image has been written.

Parameters:
ADDR_W, 6, word-address width of the instruction RAM (64 words)
MAX_WORDS, 64, largest accepted image length in words; must be at most 2**ADDR_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_data  in  8  received byte
in_valid  in  1  in_data is valid this cycle
in_ready  out  1  loader accepts a byte this cycle
load_req  in  1  one-cycle pulse (debounced button) that restarts loading
we  out  1  instruction-RAM write enable, one cycle per word
waddr  out  ADDR_W  instruction-RAM word address
wdata  out  32  instruction word
cpu_hold  out  1  high holds the processor in reset
done  out  1  one-cycle pulse when the image is verified
err  out  1  level, high while in ERR state
words_loaded  out  ADDR_W+1  number of words written by the current or last load

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high. A byte transfers when in_valid && in_ready on a rising edge.
- Reset values: state=HDR, cpu_hold=1, in_ready=1, we=0, waddr=0, wdata=0, done=0, err=0, words_loaded=0. The internal XOR accumulator and byte counter are also cleared.
- Image format: count byte N, then 4*N payload bytes with the MSB of each word first, then a checksum byte equal to the XOR of N and all payload bytes.
- HDR state:
  - Accepted byte N with 1 <= N <= MAX_WORDS: latch N, seed the XOR accumulator with N, go to DATA.
  - N == 0 or N > MAX_WORDS: go to ERR.
- DATA state:
  - Shift each accepted byte into the word register and XOR it into the accumulator.
  - On the 4th byte of a word: the next cycle drives we=1 for exactly 1 cycle, with waddr = word index (0-based) and wdata = the assembled word.
  - words_loaded increments in that same cycle.
  - After word N-1 is accepted, go to CSUM.
  - in_ready stays high and there is no stall: a byte may be accepted in the same cycle as we.
- CSUM state:
  - Accepted byte equals the accumulator: go to RUN, pulse done for 1 cycle, and drop cpu_hold on the next cycle after the transition.
  - Mismatch: go to ERR.
- RUN state: in_ready=0, cpu_hold=0, input bytes are ignored.
- ERR state: in_ready=0, cpu_hold=1, err=1. RAM contents are undefined.
- load_req:
  - In RUN or ERR: go to HDR on the next cycle, set cpu_hold=1, clear err, words_loaded, the accumulator and the byte count.
  - In HDR, DATA or CSUM: abort and restart at HDR with the same clears.
  - If load_req coincides with a byte handshake, load_req wins and the byte is dropped.
- Reset mid-load: identical to load_req, and additionally clears the outputs to their reset values. Partially written RAM words are not restored.
- Address never wraps: N <= MAX_WORDS guarantees waddr <= MAX_WORDS-1.
- Latency: last payload byte to we is 1 cycle. Checksum byte to done is 1 cycle. Checksum byte to cpu_hold low is 2 cycles.

Decomposition:
- Shared package (mips_pkg): state encoding constants (HDR, DATA, CSUM, RUN, ERR), IMEM_ADDR_W=6, IMEM_WORDS=64.
- One sub-module, byte_to_word: a 4-byte big-endian shift register with a 2-bit byte counter and a word_valid pulse. The FSM, XOR accumulator and write port stay in imem_loader.

Test Plan:
- Nominal load: bytes 02, 20,02,00,05, 20,03,00,0C, then checksum (02^20^02^00^05^20^03^00^0C) -> we at waddr 0 = 20020005, we at waddr 1 = 2003000C, done pulse, cpu_hold low 2 cycles after the checksum byte, words_loaded = 2.
- Bad checksum: the same image with final byte 00 -> both words are written, err=1, cpu_hold stays 1, in_ready=0. Then pulse load_req -> state HDR, err=0.
- Illegal count: count byte 00 -> ERR. After load_req, count byte 41 (65) -> ERR. No we pulses in either case.
- Maximum image: N=64 words with incrementing data and in_valid held high continuously -> 64 we pulses, waddr 0..63 with no wrap, done asserted, no stall cycles.
- Abort mid-word: after 6 payload bytes, pulse load_req in the same cycle as a valid byte -> the byte is dropped, state HDR, words_loaded = 0. A fresh 1-word image then loads at waddr 0.
- Reset during DATA, with in_valid gapped randomly -> all outputs at reset values the next cycle. A complete reload afterwards succeeds.
